cmul_rot_pipe: RTL and testbench

- Pipelined signed fixed-point complex multiplier. Applies a phase rotation (twiddle cos/sin) to one complex state-vector amplitude per transfer.
- Sits directly upstream of the amplitude holding register. out_valid drives that register's w_en, and {out_re, out_im} drives its data input.
- Valid/ready streaming on both sides. Fixed 3-cycle latency with a global pipeline stall.

---
 rtl/cmul_rot_pipe_pkg.sv | 41 ++++
 rtl/cmul_rot_pipe_if.sv | 26 ++
 rtl/cmul_rot_pipe_round_sat.sv | 25 ++
 rtl/cmul_rot_pipe.sv | 102 ++++++++++
 tb/tb_cmul_rot_pipe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmul_rot_pipe_pkg.sv
// Shared types, Q-format constants and width-reduction helpers for cmul_rot_pipe.
// Reduction mode is selected by CMUL_ROT_SATURATE_EN (defined: clamp, undefined: wrap).
package cmul_pkg;

    localparam int unsigned CMUL_DATA_W = 16;
    localparam int unsigned CMUL_FRAC_W = 14;

    localparam int ONE_Q    = 1 << CMUL_FRAC_W;
    localparam int RND_HALF = 1 << (CMUL_FRAC_W - 1);

    typedef struct packed {
        logic signed [CMUL_DATA_W-1:0] re;
        logic signed [CMUL_DATA_W-1:0] im;
    } cplx_t;

    // True when v is representable as a w-bit signed value.
    function automatic logic fits_w(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v <= hi) && (v >= lo);
    endfunction

    // Reduce v to w signed bits, returned sign-extended to 64 bits.
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] v,
                                                       input int unsigned w);
`ifdef CMUL_ROT_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/cmul_rot_pipe_if.sv
// Streaming bus of cmul_rot_pipe: input amplitude/twiddle channel, result channel, overflow flag.
interface cmul_rot_pipe_if #(
    parameter int unsigned DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic                     ovf;

    modport slave (
        input  in_valid, a_re, a_im, w_re, w_im, out_ready,
        output in_ready, out_valid, out_re, out_im, ovf
    );

    modport master (
        output in_valid, a_re, a_im, w_re, w_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, ovf
    );
endinterface

// File: rtl/cmul_rot_pipe_round_sat.sv
// Round-half-up and reduce one complex component to DATA_W bits.
// Clamp vs. wrap follows CMUL_ROT_SATURATE_EN via cmul_pkg::sat_or_wrap.
module cmul_round_sat
    import cmul_pkg::*;
#(
    parameter int unsigned DATA_W = CMUL_DATA_W,
    parameter int unsigned FRAC_W = CMUL_FRAC_W
) (
    input  logic signed [2*DATA_W:0]  i_sum,
    output logic signed [DATA_W-1:0]  o_res_c,
    output logic                      o_ovf_c
);
    localparam int unsigned SUM_W = 2 * DATA_W + 1;
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(64'd1 << (FRAC_W - 1));

    logic signed [SUM_W-1:0] w_rnd;
    logic signed [SUM_W-1:0] w_sh;

    // Sum of two products is at most 2^(2*DATA_W-1) in magnitude, so adding RND cannot overflow.
    assign w_rnd   = i_sum + RND;
    assign w_sh    = w_rnd >>> FRAC_W;
    assign o_ovf_c = ~fits_w(64'(w_sh), DATA_W);
    assign o_res_c = DATA_W'(sat_or_wrap(64'(w_sh), DATA_W));

endmodule

// File: rtl/cmul_rot_pipe.sv
// Three-stage signed fixed-point complex multiplier (a * w) with global stall and sticky overflow.
// Out-of-range results clamp when CMUL_ROT_SATURATE_EN is defined, otherwise wrap.
module cmul_rot_pipe
    import cmul_pkg::*;
#(
    parameter int unsigned DATA_W = CMUL_DATA_W,
    parameter int unsigned FRAC_W = CMUL_FRAC_W
) (
    input  logic           clk,
    input  logic           rst,
    cmul_rot_pipe_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = 2 * DATA_W + 1;

    logic                     w_stall_c;
    logic                     r_s1_v;
    logic signed [DATA_W-1:0] r_a_re, r_a_im, r_w_re, r_w_im;
    logic                     r_s2_v;
    logic signed [PROD_W-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
    logic signed [SUM_W-1:0]  w_re_sum, w_im_sum;
    logic signed [DATA_W-1:0] w_re_res, w_im_res;
    logic                     w_re_ovf, w_im_ovf;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_re, r_out_im;
    logic                     r_ovf;

    assign w_stall_c    = r_out_valid & ~bus.out_ready;
    assign bus.in_ready = ~w_stall_c;

    // S1: capture operands; bubbles still load data but carry valid=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v <= 1'b0;
            r_a_re <= '0;
            r_a_im <= '0;
            r_w_re <= '0;
            r_w_im <= '0;
        end else if (!w_stall_c) begin
            r_s1_v <= bus.in_valid;
            r_a_re <= bus.a_re;
            r_a_im <= bus.a_im;
            r_w_re <= bus.w_re;
            r_w_im <= bus.w_im;
        end
    end

    // S2: four full-precision partial products.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_v <= 1'b0;
            r_p_rr <= '0;
            r_p_ii <= '0;
            r_p_ri <= '0;
            r_p_ir <= '0;
        end else if (!w_stall_c) begin
            r_s2_v <= r_s1_v;
            r_p_rr <= PROD_W'(r_a_re) * PROD_W'(r_w_re);
            r_p_ii <= PROD_W'(r_a_im) * PROD_W'(r_w_im);
            r_p_ri <= PROD_W'(r_a_re) * PROD_W'(r_w_im);
            r_p_ir <= PROD_W'(r_a_im) * PROD_W'(r_w_re);
        end
    end

    assign w_re_sum = SUM_W'(r_p_rr) - SUM_W'(r_p_ii);
    assign w_im_sum = SUM_W'(r_p_ri) + SUM_W'(r_p_ir);

    cmul_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rs_re (
        .i_sum   (w_re_sum),
        .o_res_c (w_re_res),
        .o_ovf_c (w_re_ovf)
    );

    cmul_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rs_im (
        .i_sum   (w_im_sum),
        .o_res_c (w_im_res),
        .o_ovf_c (w_im_ovf)
    );

    // S3: output register; data only loads on valid items so it holds across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_ovf       <= 1'b0;
        end else if (!w_stall_c) begin
            r_out_valid <= r_s2_v;
            if (r_s2_v) begin
                r_out_re <= w_re_res;
                r_out_im <= w_im_res;
                r_ovf    <= r_ovf | w_re_ovf | w_im_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_re    = r_out_re;
    assign bus.out_im    = r_out_im;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cmul_rot_pipe.sv
// Scoreboard bench for cmul_rot_pipe: directed vectors, random streams with backpressure, mid-stream reset.
module tb_cmul_rot_pipe;
    import cmul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cmul_rot_pipe_if #(.DATA_W(CMUL_DATA_W)) bus ();

    cmul_rot_pipe #(.DATA_W(CMUL_DATA_W), .FRAC_W(CMUL_FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        cplx_t  exp;
        bit     ovf;
        longint acc;
        bit     chk_lat;
    } sb_t;

    sb_t    sb_q[$];
    sb_t    mon_s;
    cplx_t  held;
    bit     was_stall  = 1'b0;
    bit     model_ovf  = 1'b0;
    bit     lat_chk_en = 1'b1;
    bit     rnd_done   = 1'b0;
    longint cyc        = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer complex product, round half-up, then clamp or wrap to 16 bits.
    function automatic bit fits16(input longint v);
        return (v >= -32768) && (v <= 32767);
    endfunction

    function automatic shortint reduce16(input longint v);
`ifdef CMUL_ROT_SATURATE_EN
        if (v > 32767)  return 16'sd32767;
        if (v < -32768) return -16'sd32768;
`endif
        return shortint'(v);
    endfunction

    function automatic void model(input shortint ar, input shortint ai,
                                  input shortint wr, input shortint wi,
                                  output cplx_t o, output bit ov);
        longint re, im, rr, ri;
        re = longint'(ar) * longint'(wr) - longint'(ai) * longint'(wi);
        im = longint'(ar) * longint'(wi) + longint'(ai) * longint'(wr);
        rr = (re + longint'(RND_HALF)) >>> CMUL_FRAC_W;
        ri = (im + longint'(RND_HALF)) >>> CMUL_FRAC_W;
        ov = !fits16(rr) || !fits16(ri);
        o.re = reduce16(rr);
        o.im = reduce16(ri);
    endfunction

    // Present one pair from a falling edge; the expected result is queued once acceptance is certain.
    task automatic send(input shortint ar, input shortint ai, input shortint wr, input shortint wi);
        cplx_t e;
        bit    ov;
        int    waits = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_re = ar;
        bus.a_im = ai;
        bus.w_re = wr;
        bus.w_im = wi;
        #1;
        while (!bus.in_ready) begin
            if (waits++ > 50) begin
                check("send_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        model(ar, ai, wr, wi, e, ov);
        model_ovf = model_ovf | ov;
        sb_q.push_back('{exp: e, ovf: model_ovf, acc: cyc, chk_lat: lat_chk_en});
        @(posedge clk);
    endtask

    task automatic send_rand();
        send(shortint'($urandom()), shortint'($urandom()), shortint'($urandom()), shortint'($urandom()));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_queue_empty", longint'(sb_q.size()), 0);
    endtask

    // Monitor: pop on each output transfer; while stalled, outputs must hold and in_ready must be low.
    always begin
        @(negedge clk);
        #2;
        if (rst && bus.out_valid) begin
            if (bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_s = sb_q.pop_front();
                    check("out_re", longint'(bus.out_re), longint'(mon_s.exp.re));
                    check("out_im", longint'(bus.out_im), longint'(mon_s.exp.im));
                    check("ovf", longint'(bus.ovf), longint'(mon_s.ovf));
                    if (mon_s.chk_lat) check("latency", cyc - mon_s.acc, 3);
                end
                was_stall = 1'b0;
            end else begin
                check("in_ready_stalled", longint'(bus.in_ready), 0);
                if (was_stall) begin
                    check("hold_re", longint'(bus.out_re), longint'(held.re));
                    check("hold_im", longint'(bus.out_im), longint'(held.im));
                end
                held.re   = bus.out_re;
                held.im   = bus.out_im;
                was_stall = 1'b1;
            end
        end else begin
            was_stall = 1'b0;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_re      = '0;
        bus.a_im      = '0;
        bus.w_re      = '0;
        bus.w_im      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_re", longint'(bus.out_re), 0);
        check("rst_out_im", longint'(bus.out_im), 0);
        check("rst_ovf", longint'(bus.ovf), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        rst = 1'b1;

        // Unity twiddle, 90-degree rotation, rounding at +1/-1 LSB.
        send(16'sd8192, -16'sd4096, 16'sd16384, 16'sd0);
        idle();
        drain();
        check("unity_ovf_clear", longint'(bus.ovf), 0);
        send(16'sd8192, 16'sd4096, 16'sd0, 16'sd16384);
        send(16'sd1, 16'sd0, 16'sd8192, 16'sd0);
        send(-16'sd1, 16'sd0, 16'sd8192, 16'sd0);
        idle();
        drain();

        // Most-negative squared: overflows in both builds.
        send(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
        idle();
        drain();
        check("ovf_sticky", longint'(bus.ovf), 1);

        // Ten back-to-back random pairs with a 4-cycle downstream stall mid-stream.
        lat_chk_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (4) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random downstream readiness.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if (($urandom() % 5) == 0) idle();
                    send_rand();
                end
                idle();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    bus.out_ready = (($urandom() % 4) != 0);
                end
            end
        join
        @(negedge clk);
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset with three items in flight.
        lat_chk_en = 1'b1;
        send_rand();
        send_rand();
        send(-16'sd32768, 16'sd0, -16'sd32768, 16'sd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", longint'(bus.out_valid), 0);
        check("async_rst_ovf", longint'(bus.ovf), 0);
        sb_q.delete();
        model_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(16'sd8192, -16'sd4096, 16'sd16384, 16'sd0);
        idle();
        drain();
        repeat (6) @(negedge clk);
        check("post_rst_ovf", longint'(bus.ovf), 0);
        check("post_rst_quiet", longint'(bus.out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
